// File: rtl/fuzz_stim_sequencer_if.sv
// Control/response bundle between a fuzz stimulus sequencer and the
// harness that owns the netlist under test.
interface fuzz_stim_sequencer_if #(
  parameter int unsigned IN_W  = 72,
  parameter int unsigned OUT_W = 336
);
  logic              start;
  logic              abort;
  logic [31:0]       seed;
  logic [OUT_W-1:0]  dut_y;
  logic [IN_W-1:0]   stim;
  logic              stim_valid;
  logic [7:0]        vec_idx;
  logic              busy;
  logic              done;
  logic [31:0]       signature;

  modport master (
    output start, abort, seed, dut_y,
    input  stim, stim_valid, vec_idx, busy, done, signature
  );

  modport slave (
    input  start, abort, seed, dut_y,
    output stim, stim_valid, vec_idx, busy, done, signature
  );
endinterface

// File: rtl/fuzz_stim_sequencer.sv
// Seeded LFSR stimulus generator for a fuzzed netlist; compacts the netlist's
// wide output into a 32-bit MISR signature, one capture per vector.
module fuzz_stim_sequencer #(
  parameter int unsigned IN_W    = 72,
  parameter int unsigned OUT_W   = 336,
  parameter int unsigned NUM_VEC = 20,
  parameter int unsigned HOLD    = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  fuzz_stim_sequencer_if.slave bus
);

  // Shadow keeps only the words still needed to form stim: w1's low byte and w2.
  localparam int unsigned SH_W      = IN_W - 32;
  localparam int unsigned CHUNKS    = (OUT_W + 31) / 32;
  localparam int unsigned PAD_W     = CHUNKS * 32;
  localparam int unsigned HOLD_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_APPLY, S_DONE} state_t;

  state_t              state, state_nx;
  logic [IN_W-1:0]     stim_q, stim_d;
  logic                stim_valid_q, stim_valid_d;
  logic [7:0]          vec_idx_q, vec_idx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [31:0]         sig_q, sig_d;
  logic [31:0]         lfsr_q, lfsr_d;
  logic [SH_W-1:0]     shadow_q, shadow_d;
  logic [1:0]          gen_cnt_q, gen_cnt_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [31:0]         lfsr_step;
  logic [31:0]         fold;
  logic [31:0]         sig_step;
  logic [PAD_W-1:0]    y_pad;
  logic                start_ok, gen_last, hold_last, vec_last;

  assign start_ok  = bus.start && !bus.abort;
  assign gen_last  = (gen_cnt_q == 2'd2);
  assign hold_last = (hold_cnt_q == HOLD_W'(HOLD - 1));
  assign vec_last  = (vec_idx_q == 8'(NUM_VEC - 1));
  assign lfsr_step = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);
  assign y_pad     = PAD_W'(bus.dut_y);
  assign sig_step  = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : 32'h0) ^ fold;

  // XOR-fold of the zero-padded DUT output into one word
  always_comb begin
    fold = 32'h0;
    for (int unsigned i = 0; i < CHUNKS; i++) begin
      fold = fold ^ y_pad[i*32 +: 32];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start_ok) state_nx = S_GEN;
      S_GEN: begin
        if (bus.abort)    state_nx = S_IDLE;
        else if (gen_last) state_nx = S_APPLY;
      end
      S_APPLY: begin
        if (bus.abort)      state_nx = S_IDLE;
        else if (hold_last) state_nx = vec_last ? S_DONE : S_GEN;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Next values for every registered output and datapath register
  always_comb begin
    stim_d       = stim_q;
    stim_valid_d = stim_valid_q;
    vec_idx_d    = vec_idx_q;
    busy_d       = busy_q;
    done_d       = done_q;
    sig_d        = sig_q;
    lfsr_d       = lfsr_q;
    shadow_d     = shadow_q;
    gen_cnt_d    = gen_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    unique case (state)
      S_IDLE: begin
        if (start_ok) begin
          lfsr_d       = (bus.seed == 32'h0) ? 32'h1 : bus.seed;
          sig_d        = 32'h0;
          vec_idx_d    = 8'd0;
          gen_cnt_d    = 2'd0;
          busy_d       = 1'b1;
          stim_valid_d = 1'b0;
        end
      end
      S_GEN: begin
        if (bus.abort) begin
          busy_d       = 1'b0;
          stim_valid_d = 1'b0;
        end else begin
          lfsr_d    = lfsr_step;
          shadow_d  = {shadow_q[SH_W-33:0], lfsr_step};
          gen_cnt_d = gen_cnt_q + 2'd1;
          if (gen_last) begin
            stim_d       = {shadow_q, lfsr_step};
            stim_valid_d = 1'b1;
            hold_cnt_d   = '0;
          end
        end
      end
      S_APPLY: begin
        if (bus.abort) begin
          busy_d       = 1'b0;
          stim_valid_d = 1'b0;
        end else if (hold_last) begin
          sig_d        = sig_step;
          stim_valid_d = 1'b0;
          if (vec_last) begin
            done_d = 1'b1;
            busy_d = 1'b0;
          end else begin
            vec_idx_d = vec_idx_q + 8'd1;
            gen_cnt_d = 2'd0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      S_DONE: begin
        done_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim_q       <= '0;
      stim_valid_q <= 1'b0;
      vec_idx_q    <= 8'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      sig_q        <= 32'h0;
      lfsr_q       <= 32'h0;
      shadow_q     <= '0;
      gen_cnt_q    <= 2'd0;
      hold_cnt_q   <= '0;
    end else begin
      stim_q       <= stim_d;
      stim_valid_q <= stim_valid_d;
      vec_idx_q    <= vec_idx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      sig_q        <= sig_d;
      lfsr_q       <= lfsr_d;
      shadow_q     <= shadow_d;
      gen_cnt_q    <= gen_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign bus.stim       = stim_q;
  assign bus.stim_valid = stim_valid_q;
  assign bus.vec_idx    = vec_idx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.signature  = sig_q;

endmodule
